// File: rtl/btn_toggle_pkg.sv
// ---------------------------------------------------------------
// btn_toggle_pkg : shared state encoding and helpers for btn_toggle_req
// Rev 1.0
// ---------------------------------------------------------------
`default_nettype none

package btn_toggle_pkg;

  typedef enum logic [2:0] {
    IDLE         = 3'd0,
    PRESS_QUAL   = 3'd1,
    PRESSED      = 3'd2,
    REPEAT       = 3'd3,
    RELEASE_QUAL = 3'd4
  } state_e;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

`default_nettype wire

// File: rtl/bit_sync.sv
// ---------------------------------------------------------------
// bit_sync : reset-to-0 shift-chain synchroniser for one async bit
// Rev 1.0
// ---------------------------------------------------------------
`default_nettype none

module bit_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sync_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d};
    end
  end

  assign q = sync_q[STAGES-1];

endmodule

`default_nettype wire

// File: rtl/btn_toggle_req.sv
// ---------------------------------------------------------------
// btn_toggle_req : debounced pushbutton to single-cycle toggle request
// Rev 1.0
// ---------------------------------------------------------------
`default_nettype none

module btn_toggle_req
  import btn_toggle_pkg::*;
#(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int HOLD_CYCLES     = 64,
  parameter int REPEAT_CYCLES   = 16,
  parameter int REPEAT_EN       = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_in,
  input  logic en,
  output logic t_pulse,
  output logic btn_level,
  output logic repeating
);

  localparam int CNT_W = $clog2(max3(DEBOUNCE_CYCLES, HOLD_CYCLES, REPEAT_CYCLES)) + 1;
  localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] REP_LAST  = CNT_W'(REPEAT_CYCLES - 1);
  localparam logic             REP_ON    = (REPEAT_EN != 0);

  logic             btn_s;
  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             t_pulse_q, t_pulse_d;
  logic             btn_level_q, btn_level_d;
  logic             repeating_q, repeating_d;

  bit_sync #(
    .STAGES(SYNC_STAGES)
  ) u_sync (
    .clk(clk),
    .rst(rst),
    .d  (btn_in),
    .q  (btn_s)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      t_pulse_q   <= 1'b0;
      btn_level_q <= 1'b0;
      repeating_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      t_pulse_q   <= t_pulse_d;
      btn_level_q <= btn_level_d;
      repeating_q <= repeating_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q + 1'b1;
    t_pulse_d   = 1'b0;
    btn_level_d = btn_level_q;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (btn_s) state_d = PRESS_QUAL;
      end
      PRESS_QUAL: begin
        if (!btn_s) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == DEB_LAST) begin
          state_d     = PRESSED;
          cnt_d       = '0;
          btn_level_d = 1'b1;
          t_pulse_d   = en;
        end
      end
      PRESSED: begin
        if (!btn_s) begin
          state_d = RELEASE_QUAL;
          cnt_d   = '0;
        end else if (cnt_q == HOLD_LAST) begin
          // Without auto-repeat the hold timer parks here instead of wrapping.
          if (REP_ON) begin
            state_d   = REPEAT;
            cnt_d     = '0;
            t_pulse_d = en;
          end else begin
            cnt_d = cnt_q;
          end
        end
      end
      REPEAT: begin
        if (!btn_s) begin
          state_d = RELEASE_QUAL;
          cnt_d   = '0;
        end else if (cnt_q == REP_LAST) begin
          cnt_d     = '0;
          t_pulse_d = en;
        end
      end
      RELEASE_QUAL: begin
        if (btn_s) begin
          state_d = PRESSED;
          cnt_d   = '0;
        end else if (cnt_q == DEB_LAST) begin
          state_d     = IDLE;
          cnt_d       = '0;
          btn_level_d = 1'b0;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
    repeating_d = (state_d == REPEAT);
  end

  assign t_pulse   = t_pulse_q;
  assign btn_level = btn_level_q;
  assign repeating = repeating_q;

endmodule

`default_nettype wire

// File: tb/tb_btn_toggle_req.sv
// ---------------------------------------------------------------
// tb_btn_toggle_req : bench for btn_toggle_req (repeat and no-repeat builds)
// Rev 1.0
// ---------------------------------------------------------------
`default_nettype none

module tb_btn_toggle_req;

  localparam int SYNC = 2;
  localparam int DEB  = 16;
  localparam int HOLD = 64;
  localparam int REP  = 16;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic btn_in = 1'b0;
  logic en = 1'b1;
  logic tp_r, lvl_r, rep_r;
  logic tp_n, lvl_n, rep_n;
  logic tq;
  logic chk_on = 1'b0;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  btn_toggle_req #(.REPEAT_EN(1)) dut_r (
    .clk(clk), .rst(rst), .btn_in(btn_in), .en(en),
    .t_pulse(tp_r), .btn_level(lvl_r), .repeating(rep_r)
  );

  btn_toggle_req #(.REPEAT_EN(0)) dut_n (
    .clk(clk), .rst(rst), .btn_in(btn_in), .en(en),
    .t_pulse(tp_n), .btn_level(lvl_n), .repeating(rep_n)
  );

  // downstream toggle flip-flop fed by the no-repeat build
  always @(posedge clk or negedge rst) begin
    if (!rst) tq <= 1'b0;
    else if (tp_n) tq <= ~tq;
  end

  // Reference model: run lengths of synchronised samples and time held since (re)entry.
  typedef struct packed {
    logic lvl;
    logic tp;
    logic rep;
    int   ones;
    int   zr;
    int   h;
  } mst_t;

  mst_t m_r, m_n;
  logic hist[$];

  function automatic logic s_now();
    if (hist.size() < SYNC) return 1'b0;
    return hist[hist.size() - SYNC];
  endfunction

  function automatic mst_t step(input mst_t c, input logic s, input logic e, input bit ren);
    mst_t n;
    n = c;
    n.tp = 1'b0;
    if (!c.lvl) begin
      n.ones = s ? c.ones + 1 : 0;
      if (n.ones == DEB + 1) begin
        n.lvl = 1'b1; n.tp = e; n.h = 0; n.zr = 0; n.ones = 0;
      end
    end else if (!s) begin
      n.zr = c.zr + 1;
      if (n.zr == DEB + 1) begin
        n.lvl = 1'b0; n.zr = 0; n.ones = 0;
      end
    end else if (c.zr != 0) begin
      n.zr = 0; n.h = 0;
    end else begin
      n.h = c.h + 1;
      if (ren && n.h >= HOLD && ((n.h - HOLD) % REP) == 0) n.tp = e;
    end
    n.rep = ren && n.lvl && (n.zr == 0) && (n.h >= HOLD);
    return n;
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_r <= '0;
      m_n <= '0;
      hist.delete();
    end else begin
      m_r <= step(m_r, s_now(), en, 1'b1);
      m_n <= step(m_n, s_now(), en, 1'b0);
      hist.push_back(btn_in);
    end
  end

  task automatic cmp(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0b expected %0b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cmpi(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    #1;
    if (chk_on) begin
      cmp("model t_pulse rep", tp_r, m_r.tp);
      cmp("model btn_level rep", lvl_r, m_r.lvl);
      cmp("model repeating rep", rep_r, m_r.rep);
      cmp("model t_pulse norep", tp_n, m_n.tp);
      cmp("model btn_level norep", lvl_n, m_n.lvl);
      cmp("model repeating norep", rep_n, 1'b0);
    end
  end

  typedef struct {
    int   len;
    logic en;
    int   np_r;
    int   np_n;
    int   first;
    int   rise;
    int   fall;
    int   rep_on;
  } vec_t;

  task automatic run_vec(input int len, input logic e, output int np_r, output int np_n,
                         output int first, output int rise, output int fall, output int rep_on);
    np_r = 0; np_n = 0; first = -1; rise = -1; fall = -1; rep_on = -1;
    for (int n = 0; n < len + 40; n++) begin
      @(negedge clk);
      btn_in = (n < len);
      en = e;
      @(posedge clk);
      #1;
      if (tp_r) begin
        np_r++;
        if (first < 0) first = n;
      end
      if (tp_n) np_n++;
      if (lvl_n && rise < 0) rise = n;
      if (!lvl_n && rise >= 0 && fall < 0) fall = n;
      if (rep_r && rep_on < 0) rep_on = n;
    end
  endtask

  vec_t vecs[6];

  initial begin
    int np_r, np_n, first, rise, fall, rep_on, second, drop;
    logic tq_before, lvl_seen;

    vecs[0] = '{len: 10,  en: 1'b1, np_r: 0, np_n: 0, first: -1, rise: -1, fall: -1,  rep_on: -1};
    vecs[1] = '{len: 16,  en: 1'b1, np_r: 0, np_n: 0, first: -1, rise: -1, fall: -1,  rep_on: -1};
    vecs[2] = '{len: 17,  en: 1'b1, np_r: 1, np_n: 1, first: 18, rise: 18, fall: 35,  rep_on: -1};
    vecs[3] = '{len: 100, en: 1'b1, np_r: 3, np_n: 1, first: 18, rise: 18, fall: 118, rep_on: 82};
    vecs[4] = '{len: 100, en: 1'b0, np_r: 0, np_n: 0, first: -1, rise: 18, fall: 118, rep_on: 82};
    vecs[5] = '{len: 200, en: 1'b1, np_r: 9, np_n: 1, first: 18, rise: 18, fall: 218, rep_on: 82};

    repeat (3) @(posedge clk);
    #1;
    cmp("reset t_pulse", tp_r, 1'b0);
    cmp("reset btn_level", lvl_r, 1'b0);
    cmp("reset repeating", rep_r, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    chk_on = 1'b1;
    repeat (5) @(posedge clk);

    foreach (vecs[i]) begin
      tq_before = tq;
      run_vec(vecs[i].len, vecs[i].en, np_r, np_n, first, rise, fall, rep_on);
      cmpi($sformatf("vec%0d pulses rep", i), np_r, vecs[i].np_r);
      cmpi($sformatf("vec%0d pulses norep", i), np_n, vecs[i].np_n);
      cmpi($sformatf("vec%0d first pulse edge", i), first, vecs[i].first);
      cmpi($sformatf("vec%0d level rise edge", i), rise, vecs[i].rise);
      cmpi($sformatf("vec%0d level fall edge", i), fall, vecs[i].fall);
      cmpi($sformatf("vec%0d repeating start edge", i), rep_on, vecs[i].rep_on);
      cmp($sformatf("vec%0d tff q", i), tq, tq_before ^ vecs[i].np_n[0]);
    end

    // bounce: high 5, low 3, high 10, then low
    np_r = 0; np_n = 0; lvl_seen = 1'b0;
    for (int n = 0; n < 60; n++) begin
      @(negedge clk);
      btn_in = (n < 5) || (n >= 8 && n < 18);
      en = 1'b1;
      @(posedge clk);
      #1;
      if (tp_r) np_r++;
      if (tp_n) np_n++;
      if (lvl_r || lvl_n) lvl_seen = 1'b1;
    end
    cmpi("bounce pulses rep", np_r, 0);
    cmpi("bounce pulses norep", np_n, 0);
    cmp("bounce level seen", lvl_seen, 1'b0);

    // en=0 through qualification, en=1 later while still held
    np_n = 0; first = -1;
    for (int n = 0; n < 180; n++) begin
      @(negedge clk);
      btn_in = (n < 140);
      en = (n >= 100);
      @(posedge clk);
      #1;
      if (tp_n) np_n++;
      if (tp_r && first < 0) first = n;
    end
    cmpi("late en norep pulses", np_n, 0);
    cmpi("late en first repeat edge", first, 114);

    // asynchronous reset in the middle of a held press
    @(negedge clk);
    btn_in = 1'b1;
    en = 1'b1;
    repeat (30) @(posedge clk);
    #1;
    cmp("pre-reset btn_level", lvl_r, 1'b1);
    #2;
    rst = 1'b0;
    #1;
    cmp("async reset t_pulse", tp_r, 1'b0);
    cmp("async reset btn_level rep", lvl_r, 1'b0);
    cmp("async reset repeating", rep_r, 1'b0);
    cmp("async reset btn_level norep", lvl_n, 1'b0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    first = -1;
    for (int f = 0; f < 40; f++) begin
      @(posedge clk);
      #1;
      if (tp_n && first < 0) first = f;
    end
    cmpi("post-reset pulse edge", first, 18);
    @(negedge clk);
    btn_in = 1'b0;
    repeat (40) @(posedge clk);

    // glitch while PRESSED restarts the hold timer
    first = -1; second = -1; drop = 0;
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      btn_in = (n < 160) && !(n >= 40 && n < 45);
      @(posedge clk);
      #1;
      if (tp_r) begin
        if (first < 0) first = n;
        else if (second < 0) second = n;
      end
      if (n >= 18 && n <= 160 && !lvl_r) drop++;
    end
    cmpi("glitch first pulse", first, 18);
    cmpi("glitch next repeat", second, 111);
    cmpi("glitch level drops", drop, 0);

    // randomized run checked against the model
    for (int n = 0, seg = 0; n < 3000; n++) begin
      @(negedge clk);
      if (seg == 0) begin
        btn_in = ~btn_in;
        seg = ($urandom_range(0, 3) == 0) ? $urandom_range(60, 130) : $urandom_range(1, 30);
      end
      seg--;
      if ($urandom_range(0, 19) == 0) en = $urandom_range(0, 1);
      if (!rst) rst = 1'b1;
      else if ($urandom_range(0, 299) == 0) rst = 1'b0;
    end
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #2;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
